// File: rtl/inst_loader_if.sv
// Loader-side bundle: start/count command, byte stream, instruction-memory write port and status.
// The loader drives the slave modport; the program source and memory/core side use master.
interface inst_loader_if;
    logic        start;
    logic [31:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/inst_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words and writes them
// to consecutive word addresses of the instruction store while holding the core.
module inst_loader #(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus,
    output logic [1:0]   state_o
);

    // Stream handshake: a byte moves on a rising edge where in_valid && in_ready are both 1.
    // in_valid may drop at any time; in_ready is high only while collecting bytes.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q, state_d;
    logic [31:0] count_q;
    logic [31:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] asm_q;
    logic [31:0] addr_q;
    logic        err_q;

    logic start_idle;
    logic count_bad;
    logic byte_hs;
    logic last_word;

    assign start_idle = bus.start && (state_q == S_IDLE);
    assign count_bad  = bus.word_count > DEPTH_W;
    assign byte_hs    = bus.in_valid && (state_q == S_RECV);
    assign last_word  = (word_idx_q + 32'd1) == count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_idle && !count_bad) begin
                    state_d = (bus.word_count == 32'd0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (byte_hs && (byte_idx_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = last_word ? S_DONE : S_RECV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_RECV);
        bus.mem_we    = (state_q == S_WRITE);
        bus.done      = (state_q == S_DONE);
        bus.cpu_hold  = (state_q != S_IDLE);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = asm_q;
        bus.err       = err_q;
        state_o       = state_q;
    end

    // The write address runs alongside the word index so it is a plain register at write time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 32'd0;
            word_idx_q <= 32'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            addr_q     <= BASE;
            err_q      <= 1'b0;
        end else begin
            if (start_idle) begin
                if (count_bad) begin
                    err_q <= 1'b1;
                end else begin
                    err_q      <= 1'b0;
                    count_q    <= bus.word_count;
                    word_idx_q <= 32'd0;
                    byte_idx_q <= 2'd0;
                    addr_q     <= BASE;
                end
            end
            if (byte_hs) begin
                asm_q[{byte_idx_q, 3'b000} +: 8] <= bus.in_data;
                byte_idx_q                       <= byte_idx_q + 2'd1;
            end
            if (state_q == S_WRITE) begin
                word_idx_q <= word_idx_q + 32'd1;
                addr_q     <= addr_q + 32'd4;
            end
        end
    end

endmodule
